// File: rtl/fifo_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rd_ctrl
// Description : Read-domain controller of an asynchronous FIFO. Converts the
//               synchronized Gray write pointer to binary, fetches words from
//               a synchronous-read memory into a 2-entry first-word-fall-
//               through output buffer, and reports read-side occupancy.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_ctrl #(
  parameter int ADDRSIZE      = 3,
  parameter int DATASIZE      = 8,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  output logic [ADDRSIZE-1:0] raddr,
  output logic                mem_ren,
  input  logic [DATASIZE-1:0] mem_rdata,
  output logic [ADDRSIZE:0]   rptr_gray,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic [DATASIZE-1:0] rd_data,
  output logic                rempty,
  output logic                raempty,
  output logic [ADDRSIZE:0]   rlevel
);

  localparam logic [ADDRSIZE:0] AEMPTY_LVL = (ADDRSIZE+1)'(AEMPTY_THRESH);

  // Registered state
  logic [ADDRSIZE:0]   rptr_bin_q,  rptr_bin_d;
  logic [ADDRSIZE:0]   rptr_gray_q, rptr_gray_d;
  logic                inflight_q,  inflight_d;
  logic [1:0]          occ_q,       occ_d;
  logic [DATASIZE-1:0] buf0_q,      buf0_d;   // head entry
  logic [DATASIZE-1:0] buf1_q,      buf1_d;   // second entry

  // Combinational helpers
  logic [ADDRSIZE:0]   wbin;
  logic [ADDRSIZE:0]   avail;
  logic [2:0]          need;
  logic                pop;
  logic                fetch;

  // Gray-to-binary of the synchronized write pointer: each binary bit is the
  // XOR of all Gray bits at or above its position.
  always_comb begin
    wbin = '0;
    for (int i = 0; i <= ADDRSIZE; i++) begin
      wbin[i] = ^(rq2_wptr >> i);
    end
  end

  // Fetch decision: fetch while memory holds unfetched words and the buffer
  // plus the word in flight will not exceed two entries after this cycle's pop.
  always_comb begin
    avail = wbin - rptr_bin_q;
    pop   = (occ_q != 2'd0) & rd_ready;
    need  = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    fetch = (avail != '0) && (need < 3'd2);
  end

  // Next-state: read pointer advance and output buffer push/pop.
  always_comb begin
    rptr_bin_d  = rptr_bin_q;
    rptr_gray_d = rptr_gray_q;
    inflight_d  = fetch;
    occ_d       = occ_q;
    buf0_d      = buf0_q;
    buf1_d      = buf1_q;

    if (fetch) begin
      rptr_bin_d  = rptr_bin_q + 1'b1;
      rptr_gray_d = rptr_bin_d ^ (rptr_bin_d >> 1);
    end

    case ({inflight_q, pop})
      2'b10: begin
        // Push only: fill the first free slot.
        if (occ_q == 2'd0) buf0_d = mem_rdata;
        else               buf1_d = mem_rdata;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        // Pop only: second entry (if any) moves to the head.
        buf0_d = buf1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        // Push and pop together: occupancy unchanged. With a single entry
        // the incoming word becomes the head directly.
        if (occ_q == 2'd2) begin
          buf0_d = buf1_q;
          buf1_d = mem_rdata;
        end else begin
          buf0_d = mem_rdata;
        end
      end
      default: ;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rptr_bin_q  <= '0;
      rptr_gray_q <= '0;
      inflight_q  <= 1'b0;
      occ_q       <= 2'd0;
      buf0_q      <= '0;
      buf1_q      <= '0;
    end else begin
      rptr_bin_q  <= rptr_bin_d;
      rptr_gray_q <= rptr_gray_d;
      inflight_q  <= inflight_d;
      occ_q       <= occ_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
    end
  end

  // Outputs
  assign raddr     = rptr_bin_q[ADDRSIZE-1:0];
  assign mem_ren   = fetch;
  assign rptr_gray = rptr_gray_q;
  assign rd_valid  = (occ_q != 2'd0);
  assign rd_data   = buf0_q;
  assign rempty    = (occ_q == 2'd0);
  assign rlevel    = avail + (ADDRSIZE+1)'(occ_q) + (ADDRSIZE+1)'(inflight_q);
  assign raempty   = (rlevel <= AEMPTY_LVL);

endmodule
`default_nettype wire
